// File: rtl/ram_burst_sequencer_pkg.sv
// Shared encodings for the RAM burst sequencer: FSM states, op-size and read/write codes, bus widths.
package ram_burst_sequencer_pkg;

    typedef enum logic [1:0] {
        MEMSEQ_IDLE       = 2'd0,
        MEMSEQ_READ       = 2'd1,
        MEMSEQ_READ_DRAIN = 2'd2,
        MEMSEQ_WRITE      = 2'd3
    } memseq_state_t;

    localparam logic OP_SIZE_LINE = 1'b0;
    localparam logic OP_SIZE_WORD = 1'b1;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam int ADDR_BUS = 32;
    localparam int DATA_BUS = 32;

endpackage

// File: rtl/ram_burst_sequencer_burst_beat_counter.sv
// Beat offset within a line (modulo line length) plus final-beat detection, measured from the loaded start offset.
module burst_beat_counter #(
    parameter int OFF_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [OFF_W-1:0] load_offset,
    input  logic [OFF_W-1:0] load_last,
    input  logic             advance,
    input  logic             finishes_op,
    output logic [OFF_W-1:0] offset,
    output logic             final_beat
);

    logic [OFF_W-1:0] cnt;
    logic [OFF_W-1:0] start;
    logic [OFF_W-1:0] last_idx;
    logic [OFF_W-1:0] beat_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            start    <= '0;
            last_idx <= '0;
        end else if (load) begin
            cnt      <= load_offset;
            start    <= load_offset;
            last_idx <= load_last;
        end else if (advance) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Beats issued so far; wrap-safe because both operands are line offsets.
    assign beat_idx   = cnt - start;
    assign offset     = cnt;
    assign final_beat = (beat_idx == last_idx) || finishes_op;

endmodule

// File: rtl/ram_burst_sequencer.sv
// Turns arbiter-granted requests into timed single-port RAM line bursts or single-word accesses.
// Optional MEMSEQ_CRITICAL_WORD_FIRST_EN: read line bursts start at the requested word and wrap within the line.
module ram_burst_sequencer
    import ram_burst_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BUS,
    parameter int ADDR_WIDTH = 16,
    parameter int BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_BUS-1:0]   mem_addr,
    input  logic                  mem_enable,
    input  logic                  mem_rw,
    input  logic                  mem_op_size,
    input  logic                  mem_finishes_op,
    input  logic [DATA_WIDTH-1:0] mem_write,
    output logic                  mem_write_req,
    output logic [DATA_WIDTH-1:0] mem_read,
    output logic                  mem_read_valid,
    output logic                  mem_last,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int OFF_W  = $clog2(BURST_LEN);
    localparam int LINE_W = ADDR_WIDTH - OFF_W;

    memseq_state_t state, next_state;

    logic [LINE_W-1:0]     line_addr;
    logic                  pending;
    logic [ADDR_WIDTH-1:0] req_word;
    logic [OFF_W-1:0]      load_offset;
    logic [OFF_W-1:0]      load_last;
    logic [OFF_W-1:0]      beat_offset;
    logic                  load;
    logic                  advance;
    logic                  final_beat;
    logic                  unused_addr_bits;

    // Byte address to word address; upper bits wrap modulo RAM depth.
    assign req_word         = mem_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{mem_addr[ADDR_BUS-1:ADDR_WIDTH+2], mem_addr[1:0]};
    assign mem_read         = ram_rdata;

    always_comb begin
        load_offset = '0;
`ifdef MEMSEQ_CRITICAL_WORD_FIRST_EN
        if (mem_op_size == OP_SIZE_WORD || mem_rw == MEM_READ) begin
            load_offset = req_word[OFF_W-1:0];
        end
`else
        if (mem_op_size == OP_SIZE_WORD) begin
            load_offset = req_word[OFF_W-1:0];
        end
`endif
        load_last = (mem_op_size == OP_SIZE_WORD) ? '0 : OFF_W'(BURST_LEN - 1);
    end

    burst_beat_counter #(
        .OFF_W(OFF_W)
    ) u_beat_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_offset(load_offset),
        .load_last  (load_last),
        .advance    (advance),
        .finishes_op(mem_finishes_op),
        .offset     (beat_offset),
        .final_beat (final_beat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MEMSEQ_IDLE;
            line_addr <= '0;
            pending   <= 1'b0;
        end else begin
            state   <= next_state;
            pending <= (state == MEMSEQ_READ) && mem_enable;
            if (load) begin
                line_addr <= req_word[ADDR_WIDTH-1:OFF_W];
            end
        end
    end

    always_comb begin
        next_state     = state;
        load           = 1'b0;
        advance        = 1'b0;
        ram_en         = 1'b0;
        ram_we         = 1'b0;
        ram_addr       = '0;
        ram_wdata      = '0;
        mem_write_req  = 1'b0;
        mem_read_valid = 1'b0;
        mem_last       = 1'b0;
        unique case (state)
            MEMSEQ_IDLE: begin
                if (mem_enable) begin
                    load       = 1'b1;
                    next_state = (mem_rw == MEM_READ) ? MEMSEQ_READ : MEMSEQ_WRITE;
                end
            end
            MEMSEQ_READ: begin
                // Dropping enable aborts and discards the beat already in flight.
                if (!mem_enable) begin
                    next_state = MEMSEQ_IDLE;
                end else begin
                    ram_en         = 1'b1;
                    ram_addr       = {line_addr, beat_offset};
                    advance        = 1'b1;
                    mem_read_valid = pending;
                    if (final_beat) begin
                        next_state = MEMSEQ_READ_DRAIN;
                    end
                end
            end
            MEMSEQ_READ_DRAIN: begin
                next_state = MEMSEQ_IDLE;
                if (mem_enable) begin
                    mem_read_valid = pending;
                    mem_last       = 1'b1;
                end
            end
            MEMSEQ_WRITE: begin
                if (!mem_enable) begin
                    next_state = MEMSEQ_IDLE;
                end else begin
                    mem_write_req = 1'b1;
                    ram_en        = 1'b1;
                    ram_we        = 1'b1;
                    ram_addr      = {line_addr, beat_offset};
                    ram_wdata     = mem_write;
                    advance       = 1'b1;
                    if (final_beat) begin
                        mem_last   = 1'b1;
                        next_state = MEMSEQ_IDLE;
                    end
                end
            end
            default: next_state = MEMSEQ_IDLE;
        endcase
    end

endmodule

// File: doc/ram_burst_sequencer.md
Name: ram_burst_sequencer

Overview:
- Drives the single-port synchronous main RAM on behalf of the memory arbiter, which presents one granted requester at a time.
- Turns each granted request into a timed RAM access: a full cache-line burst of BURST_LEN words, or a single word.
- Generates per-beat read-valid and write-request strobes, plus a last-beat flag that releases the arbiter's grant.

Parameters:
- DATA_WIDTH, 32: word width.
- ADDR_WIDTH, 16: RAM word-address width; RAM depth is 2^ADDR_WIDTH words.
- BURST_LEN, 8: words per line burst; must be a power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- mem_addr  in  32  byte address; bits [1:0] are ignored.
- mem_enable  in  1  request active; held high by the arbiter until mem_last.
- mem_rw  in  1  `MEM_READ / `MEM_WRITE.
- mem_op_size  in  1  0 = line burst, 1 = single word.
- mem_finishes_op  in  1  early terminate: the current beat becomes the final beat.
- mem_write  in  DATA_WIDTH  write data; valid in the same cycle as mem_write_req.
- mem_write_req  out  1  requester must present the next write word this cycle.
- mem_read  out  DATA_WIDTH  read data.
- mem_read_valid  out  1  mem_read holds a valid beat.
- mem_last  out  1  final beat of the operation.
- ram_addr  out  ADDR_WIDTH  RAM word address.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write strobe.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data, one-cycle latency.

Behaviour:
- States: IDLE, READ, READ_DRAIN, WRITE. All outputs are combinational from state and registers.
- Registers: base word address, beat counter (log2 BURST_LEN bits), beat total, pending-read flag.
- Reset: state = IDLE, counter = 0, pending = 0. All strobes are 0. mem_read = ram_rdata. ram_addr/ram_wdata = 0.
- IDLE, on mem_enable:
  - Latch word address = mem_addr[ADDR_WIDTH+1:2]; upper address bits are discarded (wrap modulo RAM depth).
  - Line burst: clear the low log2(BURST_LEN) bits of the address; beat total = BURST_LEN.
  - Single word: keep the unaligned address; beat total = 1.
  - Next state is READ or WRITE according to mem_rw.
- READ:
  - Each cycle: ram_en = 1, ram_addr = {base line, counter}, counter increments modulo BURST_LEN.
  - pending is set, so the data for beat k appears on mem_read with mem_read_valid = 1 in the following cycle.
  - After issuing the final beat, go to READ_DRAIN.
  - Latency: first valid beat is 2 cycles after the enable edge; a line completes BURST_LEN+1 cycles after entering READ.
- READ_DRAIN: mem_read_valid = 1 and mem_last = 1 for the final beat, then go to IDLE.
- WRITE:
  - Each cycle: mem_write_req = 1, ram_en = 1, ram_we = 1, ram_wdata = mem_write, ram_addr as in READ.
  - One beat per cycle.
  - mem_last = 1 on the final write beat, then go to IDLE.
- mem_finishes_op sampled high during a beat:
  - WRITE: that beat is final; mem_last is asserted combinationally with it.
  - READ: that issued beat is final; go to READ_DRAIN.
- mem_enable dropping mid-operation: abort to IDLE immediately. No mem_last, no further RAM strobes. An already-issued read beat is discarded (mem_read_valid = 0).
- Reset mid-burst: immediate return to IDLE; all strobes low in the same cycle.
- Simultaneous last beat and new request: impossible, because the arbiter drops mem_enable for at least one cycle after mem_last. The block still re-samples mem_enable only in IDLE.
- Single word: exactly 1 beat with mem_last on it (read: 2 cycles, write: 1 cycle).

Optional Feature:
- Macro MEMSEQ_CRITICAL_WORD_FIRST_EN.
- Defined: read line bursts start at the requested word offset and wrap within the line, so the requested word is beat 0.
- Undefined: every line burst starts at offset 0.
- Write bursts always start at offset 0.

Decomposition:
- Into defines.v:
  - state encodings MEMSEQ_IDLE/READ/READ_DRAIN/WRITE;
  - OP_SIZE_LINE = 0, OP_SIZE_WORD = 1;
  - existing `MEM_READ/`MEM_WRITE and `ADDR_BUS/`DATA_BUS.
- One sub-module, burst_beat_counter:
  - loadable offset and beat total;
  - modulo-BURST_LEN increment;
  - final-beat flag with mem_finishes_op override.

Test Plan:
- Line read, mem_addr = 0x0000_0104, macro off:
  - ram_addr sequence 0x40..0x47 on consecutive cycles;
  - 8 valid beats matching RAM contents, mem_last on the 8th;
  - first valid 2 cycles after the enable edge.
- Same read, macro on: ram_addr 0x41..0x47, 0x40; mem_read order matches.
- Line write at 0x0000_0200 with data 0xA0..0xA7 supplied on mem_write_req: RAM words 0x80..0x87 = 0xA0..0xA7; mem_last with 0xA7; no RAM strobe afterward.
- Single-word write 0xDEADBEEF to 0x0000_0024, then single read: write takes 1 beat to word 0x09 with mem_last; read returns 0xDEADBEEF with valid and last together.
- mem_finishes_op high on beat 3 of a write burst: exactly 4 words written, mem_last on beat 3, state back in IDLE.
- rst_n low during beat 5 of a read, and separately mem_enable dropped during beat 2: strobes drop the same cycle, no mem_last; a new read afterwards completes correctly.
